// File: rtl/bsg_manycore_proc_req_mux.sv
// bsg_manycore_proc_req_mux
//   Shares one manycore endpoint TX port and its return path among num_chan_p
//   request channels. Each channel has a small request FIFO. A locking
//   round-robin arbiter issues FIFO heads. Per-channel outstanding counters
//   gate issue, and returns are steered back to their channel by tag.
//   Optional feature macro: BSG_MANYCORE_REQ_MUX_STATS_EN adds stall_cnt_o,
//   which holds one saturating 32-bit stall counter per channel.

module bsg_manycore_proc_req_mux #(
  parameter int num_chan_p         = 2,
  parameter int pkt_width_p        = 32,
  parameter int data_width_p       = 32,
  parameter int fifo_els_p         = 2,
  parameter int max_out_credits_p  = 32,
  parameter int max_chan_credits_p = 16,
  localparam int chan_id_width_lp  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int cnt_w_lp          = $clog2(max_chan_credits_p + 1),
  localparam int credit_w_lp       = $clog2(max_out_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p-1:0]             req_v_i,
  input  logic [num_chan_p*pkt_width_p-1:0] req_pkt_i,
  output logic [num_chan_p-1:0]             req_ready_o,
  output logic                              out_v_o,
  output logic [pkt_width_p-1:0]            out_packet_o,
  output logic [chan_id_width_lp-1:0]       out_chan_o,
  input  logic                              out_ready_i,
  input  logic [credit_w_lp-1:0]            out_credits_i,
  input  logic                              returned_v_i,
  input  logic [chan_id_width_lp-1:0]       returned_chan_i,
  input  logic [data_width_p-1:0]           returned_data_i,
  output logic                              returned_yumi_o,
  output logic [num_chan_p-1:0]             resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  input  logic [num_chan_p-1:0]             resp_yumi_i,
  output logic [num_chan_p-1:0]             outstanding_req_o
`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
  , output logic [num_chan_p*32-1:0]        stall_cnt_o
`endif
);

  localparam int ptr_w_lp  = $clog2(fifo_els_p);
  localparam int fcnt_w_lp = $clog2(fifo_els_p + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [chan_id_width_lp-1:0] r_rr;
  logic [chan_id_width_lp-1:0] r_lock_chan;
  logic [pkt_width_p-1:0]      r_mem    [num_chan_p][fifo_els_p];
  logic [ptr_w_lp-1:0]         r_rd_ptr [num_chan_p];
  logic [ptr_w_lp-1:0]         r_wr_ptr [num_chan_p];
  logic [fcnt_w_lp-1:0]        r_fcnt   [num_chan_p];
  logic [fcnt_w_lp-1:0]        w_fcnt_nxt [num_chan_p];
  logic [num_chan_p-1:0]       r_full;
  logic [cnt_w_lp-1:0]         r_cnt    [num_chan_p];

  logic [num_chan_p-1:0]       w_nonempty;
  logic [num_chan_p-1:0]       w_elig;
  logic [num_chan_p-1:0]       w_enq;
  logic [num_chan_p-1:0]       w_inc;
  logic [num_chan_p-1:0]       w_dec;
  logic                        w_found;
  logic [chan_id_width_lp-1:0] w_grant;
  logic [chan_id_width_lp-1:0] w_sel_chan;
  logic                        w_out_v;
  logic                        w_issue;
  logic                        w_ret_in_range;
  logic                        w_yumi;
  logic                        w_ret_bad;

  // Per-channel FIFO status, eligibility and enqueue qualification
  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      w_nonempty[c] = (r_fcnt[c] != '0);
      w_elig[c]     = w_nonempty[c] && (r_cnt[c] < cnt_w_lp'(max_chan_credits_p))
                      && (out_credits_i != '0);
      w_enq[c]      = req_v_i[c] && !r_full[c];
    end
  end

  // Round-robin search for the first eligible channel at or after the pointer
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_grant = '0;
    v_idx   = 0;
    for (int i = 0; i < num_chan_p; i++) begin
      v_idx = int'(r_rr) + i;
      if (v_idx >= num_chan_p) begin
        v_idx = v_idx - num_chan_p;
      end else begin
        v_idx = v_idx;
      end
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_grant = chan_id_width_lp'(v_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Lock FSM next state and selected channel; a stalled grant stays locked
  always_comb begin
    w_state_nxt = r_state;
    w_sel_chan  = w_grant;
    w_out_v     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_chan = w_grant;
        w_out_v    = w_found;
        if (w_found && !out_ready_i) begin
          w_state_nxt = ST_LOCK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        w_sel_chan = r_lock_chan;
        w_out_v    = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_issue      = w_out_v && out_ready_i;
  assign out_v_o      = w_out_v;
  assign out_chan_o   = w_sel_chan;
  assign out_packet_o = r_mem[w_sel_chan][r_rd_ptr[w_sel_chan]];
  assign req_ready_o  = ~r_full;
  assign resp_data_o  = returned_data_i;

  assign w_ret_in_range = ({1'b0, returned_chan_i} < (chan_id_width_lp + 1)'(num_chan_p));

  // Return steering, consume handshake and per-channel counter deltas
  always_comb begin
    resp_v_o          = '0;
    outstanding_req_o = '0;
    w_inc             = '0;
    w_dec             = '0;
    w_yumi            = 1'b0;
    w_ret_bad         = 1'b0;
    for (int c = 0; c < num_chan_p; c++) begin
      resp_v_o[c] = returned_v_i && w_ret_in_range && (returned_chan_i == chan_id_width_lp'(c));
      w_yumi      = w_yumi || (resp_v_o[c] && resp_yumi_i[c]);
      w_inc[c]    = w_issue && (w_sel_chan == chan_id_width_lp'(c));
      w_dec[c]    = resp_v_o[c] && resp_yumi_i[c] && (r_cnt[c] != '0);
      w_ret_bad   = w_ret_bad || (resp_v_o[c] && (r_cnt[c] == '0));
      outstanding_req_o[c] = (r_cnt[c] != '0);
    end
    if (returned_v_i && !w_ret_in_range) begin
      w_ret_bad = 1'b1;
    end else begin
      w_ret_bad = w_ret_bad;
    end
  end

  assign returned_yumi_o = w_yumi;

  // FIFO occupancy next values (issue always comes from a nonempty head)
  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      if (w_enq[c] && !w_inc[c]) begin
        w_fcnt_nxt[c] = r_fcnt[c] + 1'b1;
      end else if (w_inc[c] && !w_enq[c]) begin
        w_fcnt_nxt[c] = r_fcnt[c] - 1'b1;
      end else begin
        w_fcnt_nxt[c] = r_fcnt[c];
      end
    end
  end

  // FIFO data storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_chan_p; c++) begin
      if (w_enq[c]) begin
        r_mem[c][r_wr_ptr[c]] <= req_pkt_i[c*pkt_width_p +: pkt_width_p];
      end
    end
  end

  // FIFO pointers, occupancy, registered full flag and outstanding counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_chan_p; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_fcnt[c]   <= '0;
        r_cnt[c]    <= '0;
      end
      r_full <= '0;
    end else begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (w_enq[c]) begin
          r_wr_ptr[c] <= (r_wr_ptr[c] == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_wr_ptr[c] + 1'b1;
        end
        if (w_inc[c]) begin
          r_rd_ptr[c] <= (r_rd_ptr[c] == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_rd_ptr[c] + 1'b1;
        end
        r_fcnt[c] <= w_fcnt_nxt[c];
        r_full[c] <= (w_fcnt_nxt[c] == fcnt_w_lp'(fifo_els_p));
        if (w_inc[c] && !w_dec[c]) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end else if (w_dec[c] && !w_inc[c]) begin
          r_cnt[c] <= r_cnt[c] - 1'b1;
        end
      end
    end
  end

  // Arbiter state: lock FSM, captured lock channel and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_lock_chan <= '0;
      r_rr        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOCK)) begin
        r_lock_chan <= w_grant;
      end
      if (w_issue) begin
        r_rr <= (w_sel_chan == chan_id_width_lp'(num_chan_p - 1)) ? '0 : w_sel_chan + 1'b1;
      end
    end
  end

`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
  logic [31:0] r_stall [num_chan_p];

  // Saturating count of cycles a channel had a head waiting but did not issue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_chan_p; c++) begin
        r_stall[c] <= 32'd0;
      end
    end else begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (w_nonempty[c] && !w_inc[c] && (r_stall[c] != 32'hFFFF_FFFF)) begin
          r_stall[c] <= r_stall[c] + 32'd1;
        end
      end
    end
  end

  // Flatten stall counters onto the output bus
  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      stall_cnt_o[c*32 +: 32] = r_stall[c];
    end
  end
`endif

  bsg_manycore_proc_req_mux_chk u_chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bad_i     (w_ret_bad)
  );

endmodule

// Flags returns for a channel with nothing outstanding or an invalid channel tag
module bsg_manycore_proc_req_mux_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic bad_i
);

  // Report an illegal return on every offending cycle
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!bad_i) else $error("return with zero outstanding or invalid channel");
    end
  end

endmodule

// File: tb/tb_bsg_manycore_proc_req_mux.sv
// Self-checking bench for bsg_manycore_proc_req_mux: scoreboard of expected
// issues ({chan, packet}) plus a model of per-channel outstanding counts.

module tb_bsg_manycore_proc_req_mux;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_v;
  logic [63:0] req_pkt;
  logic [1:0]  req_ready;
  logic        out_v;
  logic [31:0] out_packet;
  logic        out_chan;
  logic        out_ready;
  logic [5:0]  out_credits;
  logic        returned_v;
  logic        returned_chan;
  logic [31:0] returned_data;
  logic        returned_yumi;
  logic [1:0]  resp_v;
  logic [31:0] resp_data;
  logic [1:0]  resp_yumi;
  logic [1:0]  outstanding;
`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
  logic [63:0] stall_cnt;
`endif

  int          n_checks;
  int          n_errors;
  int          m_cnt [2];
  logic [32:0] q_exp [$];

  bsg_manycore_proc_req_mux dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .req_v_i           (req_v),
    .req_pkt_i         (req_pkt),
    .req_ready_o       (req_ready),
    .out_v_o           (out_v),
    .out_packet_o      (out_packet),
    .out_chan_o        (out_chan),
    .out_ready_i       (out_ready),
    .out_credits_i     (out_credits),
    .returned_v_i      (returned_v),
    .returned_chan_i   (returned_chan),
    .returned_data_i   (returned_data),
    .returned_yumi_o   (returned_yumi),
    .resp_v_o          (resp_v),
    .resp_data_o       (resp_data),
    .resp_yumi_i       (resp_yumi),
    .outstanding_req_o (outstanding)
`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
    , .stall_cnt_o     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: at the falling edge check outstanding against the model and
  // pop/compare the scoreboard on a handshake, then advance past the rising edge.
  task automatic tick();
    logic [32:0] e;
    logic [1:0]  exp_os;
    @(negedge clk);
    exp_os = {(m_cnt[1] != 0), (m_cnt[0] != 0)};
    n_checks++;
    if (outstanding !== exp_os) begin
      n_errors++;
      $display("FAIL outstanding: got %b expected %b", outstanding, exp_os);
    end
    if (out_v === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (q_exp.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_issue: got chan %0d pkt %h, none expected", out_chan, out_packet);
      end else begin
        e = q_exp.pop_front();
        if ({out_chan, out_packet} !== e) begin
          n_errors++;
          $display("FAIL issue: got chan %0d pkt %h expected chan %0d pkt %h",
                   out_chan, out_packet, e[32], e[31:0]);
        end
        m_cnt[e[32]]++;
      end
    end
    if (returned_v && resp_yumi[returned_chan]) m_cnt[returned_chan]--;
    @(posedge clk);
    #1;
  endtask

  // Return everything the model says is outstanding, checking the return path
  task automatic drain();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 40 && m_cnt[c] > 0; k++) begin
        returned_v    = 1'b1;
        returned_chan = c[0];
        returned_data = 32'hD000_0000 + 32'(k) + 32'(c * 256);
        resp_yumi     = (c == 0) ? 2'b01 : 2'b10;
        #1;
        n_checks++;
        if (resp_v !== resp_yumi || returned_yumi !== 1'b1 || resp_data !== returned_data) begin
          n_errors++;
          $display("FAIL return_path: got resp_v %b yumi %b data %h expected %b 1 %h",
                   resp_v, returned_yumi, resp_data, resp_yumi, returned_data);
        end
        tick();
      end
    end
    returned_v = 1'b0;
    resp_yumi  = 2'b00;
  endtask

  task automatic wait_drain_queue(input int bound, input string name);
    for (int k = 0; k < bound && q_exp.size() != 0; k++) tick();
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d issues still pending, expected 0", name, q_exp.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_v !== 1'b0 || req_ready !== 2'b11 || resp_v !== 2'b00 ||
        returned_yumi !== 1'b0 || outstanding !== 2'b00) begin
      n_errors++;
      $display("FAIL reset: got v %b rdy %b resp %b yumi %b os %b expected 0 11 00 0 00",
               out_v, req_ready, resp_v, returned_yumi, outstanding);
    end
`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
    n_checks++;
    if (stall_cnt !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_stall: got %h expected 0", stall_cnt);
    end
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int sent [2];
    sent = '{0, 0};
    for (int i = 0; i < 3; i++) begin
      q_exp.push_back({1'b0, 32'hA000_0000 + 32'(i)});
      q_exp.push_back({1'b1, 32'hB000_0000 + 32'(i)});
    end
    for (int cyc = 0; cyc < 40 && (q_exp.size() != 0 || sent[0] < 3 || sent[1] < 3); cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (sent[c] < 3 && req_ready[c]) begin
          req_v[c] = 1'b1;
          req_pkt[c*32 +: 32] = ((c == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(sent[c]);
          sent[c]++;
        end else begin
          req_v[c] = 1'b0;
        end
      end
      tick();
    end
    req_v = 2'b00;
    n_checks++;
    if (q_exp.size() != 0 || out_v !== 1'b0) begin
      n_errors++;
      $display("FAIL round_robin_end: got pending %0d out_v %b expected 0 0", q_exp.size(), out_v);
    end
  endtask

  task automatic test_lock();
    out_ready = 1'b0;
    req_v = 2'b10; req_pkt[63:32] = 32'hC0C0_0001;
    tick();
    req_v = 2'b01; req_pkt[31:0] = 32'hD0D0_0002;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_v, out_chan, out_packet} !== {1'b1, 1'b1, 32'hC0C0_0001}) begin
        n_errors++;
        $display("FAIL lock_hold: got v %b chan %0d pkt %h expected 1 1 c0c00001",
                 out_v, out_chan, out_packet);
      end
      tick();
      req_v = 2'b00;
    end
    q_exp.push_back({1'b1, 32'hC0C0_0001});
    q_exp.push_back({1'b0, 32'hD0D0_0002});
    out_ready = 1'b1;
    wait_drain_queue(10, "lock");
  endtask

  task automatic test_chan_cap();
    int sent;
    sent = 0;
    drain();
    for (int i = 0; i < 16; i++) q_exp.push_back({1'b0, 32'hE000_0000 + 32'(i)});
    for (int cyc = 0; cyc < 80 && (q_exp.size() != 0 || sent < 17); cyc++) begin
      if (sent < 17 && req_ready[0]) begin
        req_v[0] = 1'b1; req_pkt[31:0] = 32'hE000_0000 + 32'(sent); sent++;
      end else begin
        req_v[0] = 1'b0;
      end
      tick();
    end
    req_v = 2'b00;
    tick(); tick();
    n_checks++;
    if (out_v !== 1'b0 || q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL cap_block: got out_v %b pending %0d expected 0 0", out_v, q_exp.size());
    end
    q_exp.push_back({1'b1, 32'hF000_0001});
    req_v = 2'b10; req_pkt[63:32] = 32'hF000_0001;
    tick();
    req_v = 2'b00;
    wait_drain_queue(5, "cap_other_chan");
    n_checks++;
    if (out_v !== 1'b0) begin
      n_errors++;
      $display("FAIL cap_still_blocked: got out_v %b expected 0", out_v);
    end
    q_exp.push_back({1'b0, 32'hE000_0010});
    returned_v = 1'b1; returned_chan = 1'b0; returned_data = 32'h1234_5678; resp_yumi = 2'b01;
    tick();
    returned_v = 1'b0; resp_yumi = 2'b00;
    wait_drain_queue(5, "cap_resume");
  endtask

  task automatic test_credits();
    drain();
    out_credits = 6'd0;
    req_v = 2'b11; req_pkt = {32'h4444_0001, 32'h6666_0001};
    tick();
    req_v = 2'b00;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_v !== 1'b0) begin
        n_errors++;
        $display("FAIL no_credit: got out_v %b expected 0", out_v);
      end
      tick();
    end
    q_exp.push_back({1'b1, 32'h4444_0001});
    q_exp.push_back({1'b0, 32'h6666_0001});
    out_credits = 6'd1;
    tick();
    n_checks++;
    if (q_exp.size() != 1) begin
      n_errors++;
      $display("FAIL credit_resume: got pending %0d expected 1", q_exp.size());
    end
    wait_drain_queue(5, "credit");
    out_credits = 6'd32;
  endtask

  task automatic test_same_cycle();
    int sent;
    sent = 0;
    drain();
    for (int i = 0; i < 3; i++) q_exp.push_back({1'b0, 32'h5500_0000 + 32'(i)});
    for (int cyc = 0; cyc < 20 && (q_exp.size() != 0 || sent < 3); cyc++) begin
      if (sent < 3 && req_ready[0]) begin
        req_v[0] = 1'b1; req_pkt[31:0] = 32'h5500_0000 + 32'(sent); sent++;
      end else begin
        req_v[0] = 1'b0;
      end
      tick();
    end
    req_v = 2'b01; req_pkt[31:0] = 32'h5500_00FF;
    tick();
    req_v = 2'b00;
    q_exp.push_back({1'b0, 32'h5500_00FF});
    returned_v = 1'b1; returned_chan = 1'b0; returned_data = 32'h0000_0033; resp_yumi = 2'b01;
    tick();
    n_checks++;
    if (q_exp.size() != 0 || outstanding[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle: got pending %0d os0 %b expected 0 1", q_exp.size(), outstanding[0]);
    end
    tick(); tick();
    n_checks++;
    if (outstanding[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_cnt3: got os0 %b after 2 returns expected 1", outstanding[0]);
    end
    tick();
    returned_v = 1'b0; resp_yumi = 2'b00;
    n_checks++;
    if (outstanding[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_zero: got os0 %b after 3 returns expected 0", outstanding[0]);
    end
  endtask

  task automatic test_reset_mid_lock();
    q_exp.push_back({1'b1, 32'h7777_0001});
    req_v = 2'b10; req_pkt[63:32] = 32'h7777_0001;
    tick();
    req_v = 2'b00;
    wait_drain_queue(5, "pre_reset");
    out_ready = 1'b0;
    req_v = 2'b01; req_pkt[31:0] = 32'h8888_0001;
    tick();
    req_pkt[31:0] = 32'h8888_0002;
    tick();
    req_v = 2'b00;
    tick();
    n_checks++;
    if (out_v !== 1'b1 || outstanding !== 2'b10) begin
      n_errors++;
      $display("FAIL pre_reset_lock: got out_v %b os %b expected 1 10", out_v, outstanding);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_v !== 1'b0 || outstanding !== 2'b00 || req_ready !== 2'b11) begin
      n_errors++;
      $display("FAIL async_reset: got out_v %b os %b rdy %b expected 0 00 11", out_v, outstanding, req_ready);
    end
`ifdef BSG_MANYCORE_REQ_MUX_STATS_EN
    n_checks++;
    if (stall_cnt !== 64'd0) begin
      n_errors++;
      $display("FAIL async_reset_stall: got %h expected 0", stall_cnt);
    end
`endif
    m_cnt = '{0, 0};
    q_exp.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_v !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_empty: got out_v %b expected 0", out_v);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    m_cnt         = '{0, 0};
    reset_n       = 1'b0;
    req_v         = 2'b00;
    req_pkt       = 64'd0;
    out_ready     = 1'b1;
    out_credits   = 6'd32;
    returned_v    = 1'b0;
    returned_chan = 1'b0;
    returned_data = 32'd0;
    resp_yumi     = 2'b00;
    test_reset();
    test_round_robin();
    test_lock();
    test_chan_cap();
    test_credits();
    test_same_cycle();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
